// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: FSM encoding, default sizes
// and the mask reset value.
package interrupt_defs;

   localparam int NUM_SRC_DEF = 8;
   localparam int ID_W_DEF    = 3;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_HOLDOFF = 2'd2;

   // Every source comes out of reset masked.
   localparam logic MASK_RST_BIT = 1'b1;

endpackage

// File: rtl/interrupt_controller_if.sv
// Control-unit side of the interrupt controller: mask access, enable, acks,
// the two request lines and status readback.
interface interrupt_controller_if
   import interrupt_defs::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int ID_W    = ID_W_DEF
);
   logic               maskWe;
   logic [NUM_SRC-1:0] maskIn;
   logic               globalEnable;
   logic               intAck;
   logic               nmiAck;
   logic               maskableInterrupt;
   logic               hardwareInterrupt;
   logic [ID_W-1:0]    causeId;
   logic [NUM_SRC-1:0] pendingOut;
   logic [NUM_SRC-1:0] maskOut;

   modport master (
      output maskWe, maskIn, globalEnable, intAck, nmiAck,
      input  maskableInterrupt, hardwareInterrupt, causeId, pendingOut, maskOut
   );

   modport slave (
      input  maskWe, maskIn, globalEnable, intAck, nmiAck,
      output maskableInterrupt, hardwareInterrupt, causeId, pendingOut, maskOut
   );
endinterface

// File: rtl/interrupt_controller_sync.sv
// Two-flop synchronizer followed by a delay flop; rise pulses for one cycle
// when the synchronized level goes from 0 to 1.
module sync_edge_detect #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] rise
);
   logic [W-1:0] s1, s2, p;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         p  <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         p  <= s2;
      end
   end

   assign rise = s2 & ~p;
endmodule

// File: rtl/interrupt_controller.sv
// Collects edge-triggered interrupt sources, latches them as pending and hands
// the lowest-index eligible one to the control unit with an ack handshake.
module interrupt_controller
   import interrupt_defs::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int ID_W    = ID_W_DEF
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic [NUM_SRC-1:0]   irqIn,
   input  logic                 nmiIn,
   interrupt_controller_if.slave cu
);
   logic [NUM_SRC-1:0] irqRise, pending, mask, elig, clr;
   logic [0:0]         nmiRise;
   logic               nmiPending, reqQ, ackTake;
   logic [1:0]         state;
   logic [ID_W-1:0]    causeQ;

   function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
      lowest_set = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (v[i]) lowest_set = ID_W'(i);
   endfunction

   sync_edge_detect #(.W(NUM_SRC)) u_irq_sync (
      .clk(Clk), .reset(reset), .din(irqIn), .rise(irqRise)
   );

   sync_edge_detect #(.W(1)) u_nmi_sync (
      .clk(Clk), .reset(reset), .din(nmiIn), .rise(nmiRise)
   );

   assign elig    = pending & ~mask & {NUM_SRC{cu.globalEnable}};
   assign ackTake = (state == ST_ASSERT) && cu.intAck;

   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_SRC; i++)
         clr[i] = ackTake && (causeQ == ID_W'(i));
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         pending    <= '0;
         nmiPending <= 1'b0;
         mask       <= {NUM_SRC{MASK_RST_BIT}};
         state      <= ST_IDLE;
         reqQ       <= 1'b0;
         causeQ     <= '0;
      end else begin
         // A fresh edge overrides a same-cycle clear so no request is lost.
         pending    <= (pending & ~clr) | irqRise;
         nmiPending <= (nmiPending & ~cu.nmiAck) | nmiRise[0];
         if (cu.maskWe) mask <= cu.maskIn;

         case (state)
            ST_IDLE: begin
               if (|elig) begin
                  causeQ <= lowest_set(elig);
                  reqQ   <= 1'b1;
                  state  <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               // causeQ stays frozen here even if a higher-priority source arrives.
               if (cu.intAck) begin
                  reqQ  <= 1'b0;
                  state <= ST_HOLDOFF;
               end else if (!elig[causeQ]) begin
                  reqQ  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            ST_HOLDOFF: state <= ST_IDLE;
            default: begin
               reqQ  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cu.maskableInterrupt = reqQ;
   assign cu.hardwareInterrupt = nmiPending;
   assign cu.causeId           = causeQ;
   assign cu.pendingOut        = pending;
   assign cu.maskOut           = mask;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: stimulus queues timed output snapshots and expected grant IDs;
// a negedge monitor compares them against the DUT as cycles come due.
module tb_interrupt_controller;
   logic       clk;
   logic       reset;
   logic [7:0] irqIn;
   logic       nmiIn;
   int         cyc = 0;
   int         nChecks = 0;
   int         nFail = 0;

   typedef struct {
      int         at;
      string      name;
      logic       mi;
      logic       hi;
      logic       chkId;
      logic [2:0] id;
      logic [7:0] pend;
      logic [7:0] mask;
   } snap_t;

   snap_t sb[$];
   int    riseQ[$];
   logic  miPrev = 1'b0;

   interrupt_controller_if #(.NUM_SRC(8), .ID_W(3)) cu ();

   interrupt_controller #(.NUM_SRC(8), .ID_W(3)) dut (
      .Clk(clk), .reset(reset), .irqIn(irqIn), .nmiIn(nmiIn), .cu(cu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int at, input string name, input logic mi,
                            input logic hi, input logic chkId, input logic [2:0] id,
                            input logic [7:0] pend, input logic [7:0] mask);
      snap_t s;
      s.at = at; s.name = name; s.mi = mi; s.hi = hi; s.chkId = chkId;
      s.id = id; s.pend = pend; s.mask = mask;
      sb.push_back(s);
   endtask

   // Monitor: grant order on each rising maskableInterrupt, plus timed snapshots.
   always @(negedge clk) begin
      int e;
      logic bad;
      if (cu.maskableInterrupt === 1'b1 && !miPrev) begin
         nChecks++;
         if (riseQ.size() == 0) begin
            nFail++;
            $display("FAIL grant_unexpected: causeId=%0d, no grant expected", cu.causeId);
         end else begin
            e = riseQ.pop_front();
            if (cu.causeId !== 3'(e)) begin
               nFail++;
               $display("FAIL grant_order: causeId=%0d, required %0d", cu.causeId, e);
            end
         end
      end
      miPrev = (cu.maskableInterrupt === 1'b1);

      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            nChecks++;
            bad = (sb[i].at != cyc) ||
                  (cu.maskableInterrupt !== sb[i].mi) ||
                  (cu.hardwareInterrupt !== sb[i].hi) ||
                  (cu.pendingOut !== sb[i].pend) ||
                  (cu.maskOut !== sb[i].mask) ||
                  (sb[i].chkId && (cu.causeId !== sb[i].id));
            if (bad) begin
               nFail++;
               $display("FAIL %s @cyc %0d: mi=%b hi=%b id=%0d pend=%h mask=%h, required mi=%b hi=%b id=%0d(chk=%b) pend=%h mask=%h at cyc %0d",
                        sb[i].name, cyc, cu.maskableInterrupt, cu.hardwareInterrupt,
                        cu.causeId, cu.pendingOut, cu.maskOut, sb[i].mi, sb[i].hi,
                        sb[i].id, sb[i].chkId, sb[i].pend, sb[i].mask, sb[i].at);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      int c;
      int d;
      reset = 1'b1; irqIn = '0; nmiIn = 1'b0;
      cu.maskWe = 1'b0; cu.maskIn = '0; cu.globalEnable = 1'b0;
      cu.intAck = 1'b0; cu.nmiAck = 1'b0;

      // Reset state, then open the mask.
      tick(2);
      expect_at(cyc, "reset_state", 0, 0, 1, 3'd0, 8'h00, 8'hFF);
      reset = 1'b0; cu.maskWe = 1'b1; cu.maskIn = 8'h00; cu.globalEnable = 1'b1;
      expect_at(cyc + 1, "mask_write", 0, 0, 0, 3'd0, 8'h00, 8'h00);
      tick(1); cu.maskWe = 1'b0;

      // Basic request on source 5 and ack; source sampled at edge c+1.
      c = cyc; irqIn[5] = 1'b1;
      expect_at(c + 2, "t2_latency",  0, 0, 0, 3'd0, 8'h00, 8'h00);
      expect_at(c + 3, "t2_pending",  0, 0, 0, 3'd0, 8'h20, 8'h00);
      expect_at(c + 4, "t2_request",  1, 0, 1, 3'd5, 8'h20, 8'h00);
      expect_at(c + 5, "t2_ack",      0, 0, 0, 3'd0, 8'h00, 8'h00);
      expect_at(c + 6, "t2_holdoff",  0, 0, 0, 3'd0, 8'h00, 8'h00);
      riseQ.push_back(5);
      tick(1); irqIn[5] = 1'b0;
      tick(3); cu.intAck = 1'b1;
      tick(1); cu.intAck = 1'b0;
      tick(1);

      // Priority freeze: 6 is granted, 2 arrives later and waits its turn.
      c = cyc; irqIn[6] = 1'b1;
      expect_at(c + 4,  "t3_req6",    1, 0, 1, 3'd6, 8'h40, 8'h00);
      expect_at(c + 7,  "t3_freeze",  1, 0, 1, 3'd6, 8'h44, 8'h00);
      expect_at(c + 8,  "t3_ack6",    0, 0, 0, 3'd0, 8'h04, 8'h00);
      expect_at(c + 9,  "t3_holdoff", 0, 0, 0, 3'd0, 8'h04, 8'h00);
      expect_at(c + 10, "t3_req2",    1, 0, 1, 3'd2, 8'h04, 8'h00);
      expect_at(c + 11, "t3_ack2",    0, 0, 0, 3'd0, 8'h00, 8'h00);
      riseQ.push_back(6); riseQ.push_back(2);
      tick(4); irqIn[2] = 1'b1;
      tick(3); cu.intAck = 1'b1;
      tick(1); cu.intAck = 1'b0;
      tick(2); cu.intAck = 1'b1;
      tick(1); cu.intAck = 1'b0; irqIn = '0;
      tick(2);

      // Masking: latched while masked, granted after unmask, withdrawn on re-mask.
      c = cyc; cu.maskWe = 1'b1; cu.maskIn = 8'h08;
      expect_at(c + 5,  "t4_masked",    0, 0, 0, 3'd0, 8'h08, 8'h08);
      expect_at(c + 6,  "t4_unmask_wr", 0, 0, 0, 3'd0, 8'h08, 8'h00);
      expect_at(c + 7,  "t4_unmask_rq", 1, 0, 1, 3'd3, 8'h08, 8'h00);
      expect_at(c + 8,  "t4_remask_wr", 1, 0, 1, 3'd3, 8'h08, 8'h08);
      expect_at(c + 9,  "t4_withdraw",  0, 0, 0, 3'd0, 8'h08, 8'h08);
      expect_at(c + 11, "t4_rerequest", 1, 0, 1, 3'd3, 8'h08, 8'h00);
      expect_at(c + 12, "t4_ack",       0, 0, 0, 3'd0, 8'h00, 8'h00);
      riseQ.push_back(3); riseQ.push_back(3);
      tick(1); cu.maskWe = 1'b0; irqIn[3] = 1'b1;
      tick(4); cu.maskWe = 1'b1; cu.maskIn = 8'h00;
      tick(1); cu.maskWe = 1'b0;
      tick(1); cu.maskWe = 1'b1; cu.maskIn = 8'h08;
      tick(1); cu.maskWe = 1'b0;
      tick(1); cu.maskWe = 1'b1; cu.maskIn = 8'h00;
      tick(1); cu.maskWe = 1'b0;
      tick(1); cu.intAck = 1'b1;
      tick(1); cu.intAck = 1'b0; irqIn = '0;
      tick(2);

      // Second edge on source 1 lands on the same edge as its ack.
      c = cyc; irqIn[1] = 1'b1;
      expect_at(c + 3, "t5_pending",  0, 0, 0, 3'd0, 8'h02, 8'h00);
      expect_at(c + 4, "t5_request",  1, 0, 1, 3'd1, 8'h02, 8'h00);
      expect_at(c + 5, "t5_collide",  0, 0, 0, 3'd0, 8'h02, 8'h00);
      expect_at(c + 6, "t5_holdoff",  0, 0, 0, 3'd0, 8'h02, 8'h00);
      expect_at(c + 7, "t5_reassert", 1, 0, 1, 3'd1, 8'h02, 8'h00);
      expect_at(c + 8, "t5_ack",      0, 0, 0, 3'd0, 8'h00, 8'h00);
      riseQ.push_back(1); riseQ.push_back(1);
      tick(1); irqIn[1] = 1'b0;
      tick(1); irqIn[1] = 1'b1;
      tick(1); irqIn[1] = 1'b0;
      tick(1); cu.intAck = 1'b1;
      tick(1); cu.intAck = 1'b0;
      tick(2); cu.intAck = 1'b1;
      tick(1); cu.intAck = 1'b0;
      tick(2);

      // NMI ignores mask/enable; a held level requests once.
      c = cyc; cu.globalEnable = 1'b0; cu.maskWe = 1'b1; cu.maskIn = 8'hFF;
      expect_at(c + 3, "t6_nmi_latency", 0, 0, 0, 3'd0, 8'h00, 8'hFF);
      expect_at(c + 4, "t6_nmi",         0, 1, 0, 3'd0, 8'h00, 8'hFF);
      expect_at(c + 5, "t6_nmi_ack",     0, 0, 0, 3'd0, 8'h00, 8'hFF);
      expect_at(c + 8, "t6_level_held",  0, 0, 0, 3'd0, 8'h00, 8'hFF);
      tick(1); cu.maskWe = 1'b0; nmiIn = 1'b1;
      tick(3); cu.nmiAck = 1'b1;
      tick(1); cu.nmiAck = 1'b0;
      tick(3); nmiIn = 1'b0;
      tick(2);

      // Both requests up, then reset drops them without an ack.
      d = cyc; cu.maskWe = 1'b1; cu.maskIn = 8'h00; cu.globalEnable = 1'b1;
      irqIn[4] = 1'b1; nmiIn = 1'b1;
      expect_at(d + 3, "t6_nmi2",  0, 1, 0, 3'd0, 8'h10, 8'h00);
      expect_at(d + 4, "t6_both",  1, 1, 1, 3'd4, 8'h10, 8'h00);
      expect_at(d + 5, "t6_reset", 0, 0, 1, 3'd0, 8'h00, 8'hFF);
      expect_at(d + 8, "t6_quiet", 0, 0, 1, 3'd0, 8'h00, 8'hFF);
      riseQ.push_back(4);
      tick(1); cu.maskWe = 1'b0; irqIn = '0; nmiIn = 1'b0;
      tick(3); reset = 1'b1;
      tick(1); reset = 1'b0;
      tick(5);

      nChecks++;
      if (sb.size() != 0) begin
         nFail++;
         $display("FAIL snapshots_left: %0d outstanding, required 0", sb.size());
      end
      nChecks++;
      if (riseQ.size() != 0) begin
         nFail++;
         $display("FAIL grants_missing: %0d outstanding, required 0", riseQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
